regfile_mux_np: RTL and testbench

- Parametrised register file with multiple read ports and one write port for the 64-bit datapath.
- It is the next generation of the team's combinational select muxes. Storage is a bank of DEPTH x WIDTH registers, and each read port is an independent DEPTH-to-1 select mux followed by an output register.
- Adds registered reads, a per-port read enable/valid pair, write-to-read bypass, and an optional hardwired zero register (XZR).

---
 rtl/regfile_mux_np.sv | 81 ++++++++
 tb/tb_regfile_mux_np.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/regfile_mux_np.sv
// regfile_mux_np: DEPTH x WIDTH register bank with NRD registered read ports.
// Each read port is a combinational DEPTH-to-1 select followed by a data
// register that only loads when that port is enabled. The write port can be
// forwarded to same-cycle reads (BYPASS), and the top entry can be hardwired
// to zero (ZERO_REG).
module regfile_mux_np #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int SEL_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [SEL_W-1:0]       wr_sel,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*SEL_W-1:0]   rd_sel,
    output logic [NRD*WIDTH-1:0]   rd_data,
    output logic [NRD-1:0]         rd_valid
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [31:0] TOP_U   = 32'(DEPTH - 1);

    logic [WIDTH-1:0] regs    [DEPTH];
    logic [SEL_W-1:0] rd_idx  [NRD];
    logic [WIDTH-1:0] rd_next [NRD];
    logic             wr_ok;

    // Writes outside the bank or to the hardwired zero entry are dropped.
    assign wr_ok = wr_en
                 && (32'(wr_sel) < DEPTH_U)
                 && !((ZERO_REG != 0) && (32'(wr_sel) == TOP_U));

    // Register bank: cleared by reset, one write per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_sel] <= wr_data;
        end
    end

    // Per-port select: out-of-range, zero entry, bypassed write, then stored value.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_idx[p]  = rd_sel[p*SEL_W +: SEL_W];
            rd_next[p] = '0;
            if (32'(rd_idx[p]) >= DEPTH_U) begin
                rd_next[p] = '0;
            end else if ((ZERO_REG != 0) && (32'(rd_idx[p]) == TOP_U)) begin
                rd_next[p] = '0;
            end else if ((BYPASS != 0) && wr_en && (wr_sel == rd_idx[p])) begin
                rd_next[p] = wr_data;
            end else begin
                rd_next[p] = regs[rd_idx[p]];
            end
        end
    end

    // Output registers: data loads only on enable and otherwise holds; valid pulses per read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p*WIDTH +: WIDTH] <= rd_next[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mux_np.sv
// Directed bench for regfile_mux_np. A table of vectors exercises the default
// configuration; short hand-written sequences cover the ZERO_REG=0/BYPASS=0
// and DEPTH=24 variants, which share the same stimulus.
module tb_regfile_mux_np;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_sel;
    logic [63:0]  wr_data;
    logic [1:0]   rd_en;
    logic [9:0]   rd_sel;
    logic [127:0] rd_data_a, rd_data_n, rd_data_s;
    logic [1:0]   rd_valid_a, rd_valid_n, rd_valid_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mux_np dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    regfile_mux_np #(.ZERO_REG(0), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_n), .rd_valid(rd_valid_n)
    );

    regfile_mux_np #(.DEPTH(24)) dut_s (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data_s), .rd_valid(rd_valid_s)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  ws;
        logic [63:0] wd;
        logic [1:0]  re;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [1:0]  ev;
        logic [63:0] ed0;
        logic [63:0] ed1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] ws,
                                input logic [63:0] wd, input logic [1:0] re,
                                input logic [4:0] rs0, input logic [4:0] rs1,
                                input logic [1:0] ev, input logic [63:0] ed0,
                                input logic [63:0] ed1);
        vec_t v;
        v.rst = rst; v.we = we; v.ws = ws; v.wd = wd; v.re = re;
        v.rs0 = rs0; v.rs1 = rs1; v.ev = ev; v.ed0 = ed0; v.ed1 = ed1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic apply(input logic rst, input logic we, input logic [4:0] ws,
                         input logic [63:0] wd, input logic [1:0] re,
                         input logic [4:0] rs0, input logic [4:0] rs1);
        reset   = rst;
        wr_en   = we;
        wr_sel  = ws;
        wr_data = wd;
        rd_en   = re;
        rd_sel  = {rs1, rs0};
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_en = '0; rd_sel = '0;

        // reset, then first read of 0 and 31
        vq.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 2'b11, 0, 31, 2'b11, 0, 0));
        // fill reg[i] = 155+i for i=0..30; outputs hold
        for (int i = 0; i < 31; i++)
            vq.push_back(mk(0, 1, 5'(i), 64'(155 + i), 2'b00, 0, 0, 2'b00, 0, 0));
        // sweep port0 over 0..31, index 31 is the zero register
        for (int i = 0; i < 32; i++)
            vq.push_back(mk(0, 0, 0, 0, 2'b01, 5'(i), 0, 2'b01,
                            (i < 31) ? 64'(155 + i) : 64'd0, 0));
        // same-cycle hazard with bypass
        vq.push_back(mk(0, 1, 5, 343, 2'b00, 0, 0, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 5, 4123, 2'b01, 5, 0, 2'b01, 4123, 0));
        vq.push_back(mk(0, 0, 0, 0, 2'b01, 5, 0, 2'b01, 4123, 0));
        // zero register ignores writes, even same cycle
        vq.push_back(mk(0, 1, 31, 64'hDEAD, 2'b11, 31, 31, 2'b11, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 2'b11, 31, 31, 2'b11, 0, 0));
        // port independence and hold
        vq.push_back(mk(0, 1, 7, 64'h777, 2'b10, 0, 6, 2'b10, 0, 161));
        vq.push_back(mk(0, 0, 0, 0, 2'b01, 7, 0, 2'b01, 64'h777, 161));
        vq.push_back(mk(0, 0, 0, 0, 2'b11, 7, 7, 2'b11, 64'h777, 64'h777));
        vq.push_back(mk(0, 0, 0, 0, 2'b00, 1, 2, 2'b00, 64'h777, 64'h777));
        // reset wins over a concurrent write and reads
        vq.push_back(mk(1, 1, 3, 64'hFF, 2'b11, 3, 3, 2'b00, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 2'b11, 3, 0, 2'b11, 0, 0));

        for (int k = 0; k < vq.size(); k++) begin
            apply(vq[k].rst, vq[k].we, vq[k].ws, vq[k].wd, vq[k].re, vq[k].rs0, vq[k].rs1);
            chk($sformatf("vec%0d valid", k), 64'(rd_valid_a), 64'(vq[k].ev));
            chk($sformatf("vec%0d d0", k), rd_data_a[63:0], vq[k].ed0);
            chk($sformatf("vec%0d d1", k), rd_data_a[127:64], vq[k].ed1);
        end

        // ZERO_REG=0 / BYPASS=0 variant against the default instance
        apply(1, 0, 0, 0, 2'b00, 0, 0);
        apply(0, 1, 31, 64'hDEAD, 2'b00, 0, 0);
        apply(0, 0, 0, 0, 2'b01, 31, 0);
        chk("nz valid", 64'(rd_valid_n), 64'(2'b01));
        chk("nz reg31", rd_data_n[63:0], 64'hDEAD);
        chk("a reg31", rd_data_a[63:0], 64'h0);
        apply(0, 1, 5, 343, 2'b00, 0, 0);
        apply(0, 1, 5, 4123, 2'b01, 5, 0);
        chk("nz nobypass", rd_data_n[63:0], 64'd343);
        chk("a bypass", rd_data_a[63:0], 64'd4123);
        apply(0, 0, 0, 0, 2'b01, 5, 0);
        chk("nz after", rd_data_n[63:0], 64'd4123);
        chk("a after", rd_data_a[63:0], 64'd4123);

        // DEPTH=24: out-of-range write and read, zero register at 23
        apply(1, 0, 0, 0, 2'b00, 0, 0);
        apply(0, 1, 0, 64'h11, 2'b00, 0, 0);
        apply(0, 1, 30, 64'hBEEF, 2'b11, 30, 30);
        chk("s oor bypass d0", rd_data_s[63:0], 64'h0);
        chk("s oor bypass d1", rd_data_s[127:64], 64'h0);
        apply(0, 1, 23, 64'hDEAD, 2'b00, 0, 0);
        apply(0, 0, 0, 0, 2'b11, 23, 0);
        chk("s valid", 64'(rd_valid_s), 64'(2'b11));
        chk("s reg23", rd_data_s[63:0], 64'h0);
        chk("s reg0", rd_data_s[127:64], 64'h11);
        apply(0, 0, 0, 0, 2'b11, 31, 30);
        chk("s reg31", rd_data_s[63:0], 64'h0);
        chk("s reg30", rd_data_s[127:64], 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
